trap_shaper_peak: RTL and testbench

// Parametrised trapezoidal shaper with pole-zero correction and a peak-capture FSM. Successor to the fixed per-variant filters.

---
 rtl/trap_shaper_peak.sv | 221 ++++++++++++++++++++++
 tb/tb_trap_shaper_peak.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_shaper_peak.sv
// Purpose : trapezoidal shaper (K/L delay-line difference, pole-zero corrected) with a peak-capture FSM.
// Latency : input_data sampled at edge t reaches output_data after edge t+4; a report lands one edge after TRACK ends.
// Backpr. : none; one sample is accepted every clk and the block never stalls.
module trap_shaper_peak #(
  parameter int SIZE_ADC_DATA    = 12,
  parameter int SIZE_FILTER_DATA = 24,
  parameter int SIZE_ACC         = 32,
  parameter int DELAY_K          = 8,
  parameter int DELAY_L          = 12,
  parameter int M_COEF           = 0,
  parameter int SHIFT            = 0,
  parameter int MAX_WIDTH        = 64,
  parameter int HOLDOFF          = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic        [SIZE_ADC_DATA-1:0]    input_data,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  output logic signed [SIZE_FILTER_DATA-1:0] output_data,
  output logic                               peak_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_value,
  output logic                               peak_pileup,
  output logic        [15:0]                 peak_count
);

  localparam int LP_DEPTH  = DELAY_K + DELAY_L;
  localparam int LP_WCNT_W = $clog2(MAX_WIDTH + 1);
  localparam int LP_HCNT_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF);

  localparam logic        [LP_WCNT_W-1:0]        LP_WCNT_MAX  = LP_WCNT_W'(MAX_WIDTH);
  localparam logic        [LP_HCNT_W-1:0]        LP_HCNT_LAST = LP_HCNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic        [SIZE_ACC-1:0]         LP_M         = SIZE_ACC'(M_COEF);
  localparam logic signed [SIZE_FILTER_DATA-1:0] LP_OUT_MAX   = {1'b0, {(SIZE_FILTER_DATA-1){1'b1}}};
  localparam logic signed [SIZE_FILTER_DATA-1:0] LP_OUT_MIN   = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // r_x[0] is the x stage (newest sample); r_x[i] holds x[n-i].
  logic        [SIZE_ADC_DATA-1:0]    r_x [0:LP_DEPTH];
  logic        [SIZE_ACC-1:0]         r_d;
  logic        [SIZE_ACC-1:0]         r_p;
  logic        [SIZE_ACC-1:0]         r_r;
  logic signed [SIZE_ACC-1:0]         r_s;
  logic signed [SIZE_FILTER_DATA-1:0] r_out;

  logic        [SIZE_ACC-1:0]         w_d;
  logic        [SIZE_ACC-1:0]         w_p_nxt;
  logic        [SIZE_ACC-1:0]         w_r_nxt;
  logic signed [SIZE_ACC-1:0]         w_sh;
  logic        [SIZE_ACC-SIZE_FILTER_DATA:0] w_hi;
  logic signed [SIZE_FILTER_DATA-1:0] w_sat;

  // All accumulator arithmetic is modular; wrap-around cancels out over a pulse.
  assign w_d     = SIZE_ACC'(r_x[0]) - SIZE_ACC'(r_x[DELAY_K])
                 - SIZE_ACC'(r_x[DELAY_L]) + SIZE_ACC'(r_x[LP_DEPTH]);
  assign w_p_nxt = r_p + r_d;
  assign w_r_nxt = w_p_nxt + LP_M * r_d;

  // Saturate only at the output: in range when every bit above the output sign bit matches it.
  assign w_sh  = r_s >>> SHIFT;
  assign w_hi  = w_sh[SIZE_ACC-1:SIZE_FILTER_DATA-1];
  assign w_sat = ((&w_hi) || !(|w_hi)) ? w_sh[SIZE_FILTER_DATA-1:0]
               : (w_sh[SIZE_ACC-1] ? LP_OUT_MIN : LP_OUT_MAX);

  // Input stage and delay line; clear flushes history so the next pulse starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= LP_DEPTH; i++) r_x[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i <= LP_DEPTH; i++) r_x[i] <= '0;
    end else begin
      r_x[0] <= input_data;
      for (int i = 1; i <= LP_DEPTH; i++) r_x[i] <= r_x[i-1];
    end
  end

  // Difference, trapezoid accumulator with pole-zero term, second accumulator, saturated output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d   <= '0;
      r_p   <= '0;
      r_r   <= '0;
      r_s   <= '0;
      r_out <= '0;
    end else if (clear) begin
      r_d   <= '0;
      r_p   <= '0;
      r_r   <= '0;
      r_s   <= '0;
      r_out <= '0;
    end else begin
      r_d   <= w_d;
      r_p   <= w_p_nxt;
      r_r   <= w_r_nxt;
      r_s   <= r_s + $signed(r_r);
      r_out <= w_sat;
    end
  end

  assign output_data = r_out;

  // ---------------------------------------------------------------------------
  // Peak-capture FSM, driven by the registered output
  // ---------------------------------------------------------------------------
  state_t                             r_state, w_state_nxt;
  logic signed [SIZE_FILTER_DATA-1:0] r_max, w_max_nxt, w_max_cur;
  logic        [LP_WCNT_W-1:0]        r_wcnt, w_wcnt_nxt;
  logic        [LP_HCNT_W-1:0]        r_hcnt, w_hcnt_nxt;
  logic                               r_above;
  logic                               w_above;
  logic                               w_report;
  logic                               w_report_pu;

  logic                               r_pv;
  logic signed [SIZE_FILTER_DATA-1:0] r_pval;
  logic                               r_ppu;
  logic        [15:0]                 r_pcnt;

  assign w_above   = (r_out > threshold);
  assign w_max_cur = (r_out > r_max) ? r_out : r_max;

  // State and per-pulse bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_max   <= '0;
      r_wcnt  <= '0;
      r_hcnt  <= '0;
      r_above <= 1'b0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_max   <= '0;
      r_wcnt  <= '0;
      r_hcnt  <= '0;
      r_above <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_max   <= w_max_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_above <= w_above;
    end
  end

  // Next state and report decision. IDLE arms on a rising crossing so that a level
  // sitting above threshold after a forced pile-up report is not reported again.
  always_comb begin
    w_state_nxt = r_state;
    w_max_nxt   = r_max;
    w_wcnt_nxt  = r_wcnt;
    w_hcnt_nxt  = r_hcnt;
    w_report    = 1'b0;
    w_report_pu = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_above && !r_above) begin
          w_state_nxt = ST_TRACK;
          w_max_nxt   = r_out;
          w_wcnt_nxt  = LP_WCNT_W'(1);
        end
      end
      ST_TRACK: begin
        w_max_nxt  = w_max_cur;
        w_wcnt_nxt = r_wcnt + LP_WCNT_W'(1);
        if (!w_above || (r_wcnt == LP_WCNT_MAX)) begin
          w_report    = 1'b1;
          w_report_pu = w_above;
          w_hcnt_nxt  = '0;
          w_state_nxt = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_hcnt == LP_HCNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_hcnt_nxt  = '0;
        end else begin
          w_hcnt_nxt = r_hcnt + LP_HCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Report registers: one-cycle strobe, value and pile-up flag held until the next report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pv   <= 1'b0;
      r_pval <= '0;
      r_ppu  <= 1'b0;
      r_pcnt <= '0;
    end else if (clear) begin
      r_pv   <= 1'b0;
      r_pval <= '0;
      r_ppu  <= 1'b0;
      r_pcnt <= '0;
    end else begin
      r_pv <= w_report;
      if (w_report) begin
        r_pval <= w_max_cur;
        r_ppu  <= w_report_pu;
        r_pcnt <= r_pcnt + 16'd1;
      end
    end
  end

  assign peak_valid  = r_pv;
  assign peak_value  = r_pval;
  assign peak_pileup = r_ppu;
  assign peak_count  = r_pcnt;

endmodule

// File: tb/tb_trap_shaper_peak.sv
// Purpose : self-checking bench for trap_shaper_peak (24-bit default instance plus a 12-bit saturating one).
// Latency : expected outputs are queued when a sample is driven and popped four edges later.
// Backpr. : none; one sample driven per clock.
module tb_trap_shaper_peak;

  localparam int K  = 8;
  localparam int L  = 12;
  localparam int D  = K + L;
  localparam int SH = 0;

  logic               clk = 1'b0;
  logic               reset;
  logic               clear;
  logic        [11:0] input_data;
  logic signed [23:0] threshold;
  logic signed [23:0] output_data;
  logic               peak_valid;
  logic signed [23:0] peak_value;
  logic               peak_pileup;
  logic        [15:0] peak_count;

  logic signed [11:0] thr12;
  logic signed [11:0] sat_out;
  logic               sat_pv;
  logic signed [11:0] sat_pval;
  logic               sat_pu;
  logic        [15:0] sat_cnt;

  always #5 clk = ~clk;

  trap_shaper_peak u_dut (
    .clk(clk), .reset(reset), .clear(clear), .input_data(input_data), .threshold(threshold),
    .output_data(output_data), .peak_valid(peak_valid), .peak_value(peak_value),
    .peak_pileup(peak_pileup), .peak_count(peak_count)
  );

  trap_shaper_peak #(.SIZE_FILTER_DATA(12)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .input_data(input_data), .threshold(thr12),
    .output_data(sat_out), .peak_valid(sat_pv), .peak_value(sat_pval),
    .peak_pileup(sat_pu), .peak_count(sat_cnt)
  );

  typedef struct {
    logic [11:0] x;
    longint      y;
  } vec_t;

  vec_t   imp_tbl [40];
  longint hist [D];
  longint q24 [$];
  longint q12 [$];
  int     checks = 0;
  int     errors = 0;
  int     n_rep  = 0;
  longint last_val;
  int     last_pu;
  int     last_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unit-impulse response of the shaper written in closed form.
  function automatic longint trap_h(input int i);
    if (i < K)      return longint'(i + 1);
    else if (i < L) return longint'(K);
    else            return longint'(K + L - 1 - i);
  endfunction

  // Direct convolution against the sample history, then shift and clamp to w bits.
  function automatic longint model_y(input int w);
    longint acc = 0;
    longint lim = (longint'(1) <<< (w - 1));
    for (int i = 0; i < D; i++) acc += hist[i] * trap_h(i);
    acc = acc >>> SH;
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim)    acc = -lim;
    return acc;
  endfunction

  task automatic model_restart(input int zeros);
    for (int i = 0; i < D; i++) hist[i] = 0;
    q24.delete();
    q12.delete();
    repeat (zeros) begin
      q24.push_back(0);
      q12.push_back(0);
    end
    n_rep = 0;
  endtask

  // Drive one sample (optionally with clear), queue its expected output, compare what is due now.
  task automatic step(input logic [11:0] x, input logic clr, input logic use_tbl, input longint y_tbl);
    input_data = x;
    clear      = clr;
    if (clr) begin
      model_restart(5);
    end else begin
      for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = longint'(x);
      q24.push_back(use_tbl ? y_tbl : model_y(24));
      q12.push_back(model_y(12));
    end
    @(posedge clk);
    #1;
    if (q24.size() == 0 || q12.size() == 0) begin
      chk("queue_underflow", 1, 0);
    end else begin
      chk("out24", longint'(output_data), q24.pop_front());
      chk("out12", longint'(sat_out), q12.pop_front());
    end
    if (peak_valid) begin
      n_rep++;
      last_val = longint'(peak_value);
      last_pu  = int'(peak_pileup);
      last_cnt = int'(peak_count);
    end
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"},   longint'(output_data), 0);
    chk({tag, "_pv"},    longint'(peak_valid), 0);
    chk({tag, "_pval"},  longint'(peak_value), 0);
    chk({tag, "_pu"},    longint'(peak_pileup), 0);
    chk({tag, "_pcnt"},  longint'(peak_count), 0);
    chk({tag, "_sat"},   longint'(sat_out), 0);
  endtask

  task automatic chk_report(input string tag, input int n, input longint v, input int pu, input int cnt);
    chk({tag, "_nrep"}, longint'(n_rep), longint'(n));
    chk({tag, "_val"},  last_val, v);
    chk({tag, "_pu"},   longint'(last_pu), longint'(pu));
    chk({tag, "_cnt"},  longint'(last_cnt), longint'(cnt));
  endtask

  initial begin
    // Impulse table: one sample of 100, expected trapezoid 100..800, 800 x5, 700..0.
    for (int i = 0; i < 40; i++) begin
      imp_tbl[i].x = (i == 0) ? 12'd100 : 12'd0;
      if (i < 8)       imp_tbl[i].y = 100 * (i + 1);
      else if (i < 12) imp_tbl[i].y = 800;
      else if (i < 20) imp_tbl[i].y = 100 * (19 - i);
      else             imp_tbl[i].y = 0;
    end
    last_val = 0; last_pu = 0; last_cnt = 0;
    reset = 1'b0; clear = 1'b0; input_data = '0;
    threshold = 24'sd50; thr12 = 12'sd50;

    // 1: reset held with random input, then release with input 0.
    repeat (3) begin
      input_data = 12'($urandom_range(0, 4095));
      @(posedge clk);
      #1;
      chk_all_zero("rst");
    end
    reset = 1'b1;
    input_data = '0;
    model_restart(4);
    repeat (12) step(12'd0, 1'b0, 1'b0, 0);
    chk("rst_no_report", longint'(n_rep), 0);

    // 2: single impulse, table-driven.
    for (int i = 0; i < 40; i++) step(imp_tbl[i].x, 1'b0, 1'b1, imp_tbl[i].y);
    repeat (10) step(12'd0, 1'b0, 1'b0, 0);
    chk_report("imp", 1, 800, 0, 1);
    chk("imp_hold_val", longint'(peak_value), 800);
    chk("imp_hold_cnt", longint'(peak_count), 1);

    // 3: step to 100 -> 9600, one forced pile-up report, none after.
    step(12'd0, 1'b1, 1'b0, 0);
    repeat (200) step(12'd100, 1'b0, 1'b0, 0);
    chk("step_level", longint'(output_data), 9600);
    chk_report("step", 1, 9600, 1, 1);
    repeat (40) step(12'd0, 1'b0, 1'b0, 0);
    chk("step_single", longint'(n_rep), 1);

    // 4: saturation of the 12-bit instance on a full-scale step.
    step(12'd0, 1'b1, 1'b0, 0);
    repeat (40) step(12'd4095, 1'b0, 1'b0, 0);
    chk("sat_clamp", longint'(sat_out), 2047);
    chk("sat_wide", longint'(output_data), 4095 * 96);
    repeat (30) step(12'd0, 1'b0, 1'b0, 0);

    // Random sparse pulses against the convolution model.
    step(12'd0, 1'b1, 1'b0, 0);
    repeat (150) begin
      if ($urandom_range(0, 7) == 0) step(12'($urandom_range(0, 4095)), 1'b0, 1'b0, 0);
      else                           step(12'd0, 1'b0, 1'b0, 0);
    end
    repeat (25) step(12'd0, 1'b0, 1'b0, 0);

    // 5: clear during the impulse ramp, then a normal impulse.
    step(12'd0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 7; i++) step(imp_tbl[i].x, 1'b0, 1'b1, imp_tbl[i].y);
    step(12'd0, 1'b1, 1'b0, 0);
    chk_all_zero("clr");
    repeat (10) step(12'd0, 1'b0, 1'b0, 0);
    chk("clr_no_report", longint'(n_rep), 0);
    chk("clr_cnt", longint'(peak_count), 0);
    for (int i = 0; i < 40; i++) step(imp_tbl[i].x, 1'b0, 1'b1, imp_tbl[i].y);
    repeat (10) step(12'd0, 1'b0, 1'b0, 0);
    chk_report("clr_imp", 1, 800, 0, 1);

    // 6: async reset mid-TRACK, then two impulses 10 apart -> one report, max 1000.
    step(12'd0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) step(imp_tbl[i].x, 1'b0, 1'b1, imp_tbl[i].y);
    chk("ar_pre_out", longint'(output_data), 600);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("ar");
    repeat (2) begin
      input_data = 12'($urandom_range(0, 4095));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    input_data = '0;
    model_restart(4);
    repeat (8) step(12'd0, 1'b0, 1'b0, 0);
    chk("ar_no_report", longint'(n_rep), 0);
    for (int i = 0; i < 60; i++) step((i == 0 || i == 10) ? 12'd100 : 12'd0, 1'b0, 1'b0, 0);
    chk_report("pile", 1, 1000, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
